// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer sequencer.
// Holds the SPI opcodes, register addresses, the measure-mode value,
// the sequencer state encoding and the per-window byte table.
package accel_pkg;

    localparam logic [7:0] OP_WRITE          = 8'h0A;
    localparam logic [7:0] OP_READ           = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL     = 8'h2D;
    localparam logic [7:0] REG_DATAY0        = 8'h10;
    localparam logic [7:0] POWER_CTL_MEASURE = 8'h02;

    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_GAP,
        ST_WAIT,
        ST_READ,
        ST_UPDATE
    } state_t;

    // Byte idx of a CS-low window. Read bytes 2..5 are dummies that clock
    // out YL, YH, ZL, ZH from the accelerometer.
    function automatic logic [7:0] seq_byte(input logic is_read, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (is_read) begin
            if (idx == 3'd0)      b = OP_READ;
            else if (idx == 3'd1) b = REG_DATAY0;
        end else begin
            case (idx)
                3'd0:    b = OP_WRITE;
                3'd1:    b = REG_POWER_CTL;
                3'd2:    b = POWER_CTL_MEASURE;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/accel_sequencer_spi_byte_engine.sv
// spi_byte_engine: shifts one SPI mode-0 byte per start pulse, MSB first.
// Ports: clk, reset (sync, active low), start/tx_byte (load a byte; MOSI
// shows its MSB from the next edge), MISO (sampled on SCLK rise),
// rx_byte (received byte), done (high in the cycle before the final SCLK
// fall; a start in that cycle chains the next byte with no gap),
// SCLK, MOSI.
module spi_byte_engine #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       MISO,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       SCLK,
    output logic       MOSI
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active_reg, active_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [3:0]       edge_cnt_reg, edge_cnt_next;   // SCLK edges already issued
    logic             sclk_reg, sclk_next;
    logic [7:0]       tx_sh_reg, tx_sh_next;
    logic [7:0]       rx_sh_reg, rx_sh_next;

    assign done    = active_reg && (edge_cnt_reg == 4'd15) && (div_cnt_reg == DIV_LAST);
    assign rx_byte = rx_sh_reg;
    assign SCLK    = sclk_reg;
    assign MOSI    = tx_sh_reg[7];

    always_comb begin
        active_next   = active_reg;
        div_cnt_next  = div_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        sclk_next     = sclk_reg;
        tx_sh_next    = tx_sh_reg;
        rx_sh_next    = rx_sh_reg;
        if (start) begin
            // Also covers the final fall of a previous byte when chained.
            active_next   = 1'b1;
            div_cnt_next  = '0;
            edge_cnt_next = '0;
            sclk_next     = 1'b0;
            tx_sh_next    = tx_byte;
        end else if (active_reg) begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_next  = '0;
                edge_cnt_next = edge_cnt_reg + 4'd1;
                if (!edge_cnt_reg[0]) begin
                    sclk_next  = 1'b1;
                    rx_sh_next = {rx_sh_reg[6:0], MISO};
                end else begin
                    sclk_next  = 1'b0;
                    tx_sh_next = {tx_sh_reg[6:0], 1'b0};
                    if (edge_cnt_reg == 4'd15) begin
                        active_next = 1'b0;
                        tx_sh_next  = 8'h00;
                    end
                end
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_reg   <= 1'b0;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
        end else begin
            active_reg   <= active_next;
            div_cnt_reg  <= div_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            sclk_reg     <= sclk_next;
            tx_sh_reg    <= tx_sh_next;
            rx_sh_reg    <= rx_sh_next;
        end
    end

endmodule

// File: rtl/accel_sequencer.sv
// accel_sequencer: configures an SPI accelerometer into measure mode, then
// periodically reads the Y and Z axes.
// Ports: clk, reset (sync, active low), enable (permits sampling), MISO,
// MOSI, SCLK, CS (active low), Y_value/Z_value (last samples), valid
// (one-cycle update pulse), init_done, busy (CS low).
module accel_sequencer
    import accel_pkg::*;
#(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int CS_GAP        = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        MISO,
    output logic        MOSI,
    output logic        SCLK,
    output logic        CS,
    output logic [15:0] Y_value,
    output logic [15:0] Z_value,
    output logic        valid,
    output logic        init_done,
    output logic        busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    state_t           state_reg, state_next;
    logic [2:0]       byte_cnt_reg, byte_cnt_next;
    logic             tail_reg, tail_next;        // last byte shifted, CS still low
    logic [DIV_W-1:0] tail_cnt_reg, tail_cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [PER_W-1:0] period_cnt_reg, period_cnt_next;
    logic             cs_reg, cs_next;
    logic [7:0]       cap_reg [4];                // YL, YH, ZL, ZH
    logic [7:0]       cap_next [4];
    logic [15:0]      y_reg, y_next, z_reg, z_next;
    logic             valid_reg, valid_next;
    logic             init_done_reg, init_done_next;

    logic       eng_start, eng_done;
    logic [7:0] eng_tx, eng_rx;
    logic       is_read;
    logic [2:0] last_idx;
    logic [1:0] cap_idx;

    assign is_read  = (state_reg == ST_READ);
    assign last_idx = is_read ? 3'd5 : 3'd2;
    assign cap_idx  = 2'(byte_cnt_reg - 3'd2);

    spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk     (clk),
        .reset   (reset),
        .start   (eng_start),
        .tx_byte (eng_tx),
        .MISO    (MISO),
        .rx_byte (eng_rx),
        .done    (eng_done),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        tail_next      = tail_reg;
        tail_cnt_next  = tail_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        cs_next        = cs_reg;
        y_next         = y_reg;
        z_next         = z_reg;
        valid_next     = 1'b0;
        init_done_next = init_done_reg;
        eng_start      = 1'b0;
        eng_tx         = 8'h00;
        for (int i = 0; i < 4; i++) cap_next[i] = cap_reg[i];
        // Saturates, so an expiry is remembered but never counted twice.
        period_cnt_next = (period_cnt_reg == PER_LAST) ? period_cnt_reg
                                                       : period_cnt_reg + PER_W'(1);
        case (state_reg)
            ST_INIT_WR, ST_READ: begin
                if (cs_reg) begin
                    // Only reachable right after reset: open the init window.
                    eng_start     = 1'b1;
                    eng_tx        = seq_byte(is_read, 3'd0);
                    cs_next       = 1'b0;
                    byte_cnt_next = 3'd0;
                    tail_next     = 1'b0;
                end else if (tail_reg) begin
                    if (tail_cnt_reg == DIV_LAST) begin
                        cs_next = 1'b1;
                        if (is_read) begin
                            state_next = ST_UPDATE;
                            y_next     = {cap_reg[1], cap_reg[0]};
                            z_next     = {cap_reg[3], cap_reg[2]};
                            valid_next = 1'b1;
                        end else begin
                            state_next     = ST_GAP;
                            gap_cnt_next   = '0;
                            init_done_next = 1'b1;
                        end
                    end else begin
                        tail_cnt_next = tail_cnt_reg + DIV_W'(1);
                    end
                end else if (eng_done) begin
                    if (is_read && byte_cnt_reg >= 3'd2) cap_next[cap_idx] = eng_rx;
                    if (byte_cnt_reg == last_idx) begin
                        tail_next     = 1'b1;
                        tail_cnt_next = '0;
                    end else begin
                        eng_start     = 1'b1;
                        eng_tx        = seq_byte(is_read, byte_cnt_reg + 3'd1);
                        byte_cnt_next = byte_cnt_reg + 3'd1;
                    end
                end
            end
            ST_UPDATE: begin
                state_next   = ST_GAP;
                gap_cnt_next = '0;
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) state_next = ST_WAIT;
                else gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
            ST_WAIT: begin
                if (enable && period_cnt_reg == PER_LAST) begin
                    state_next      = ST_READ;
                    eng_start       = 1'b1;
                    eng_tx          = seq_byte(1'b1, 3'd0);
                    cs_next         = 1'b0;
                    byte_cnt_next   = 3'd0;
                    tail_next       = 1'b0;
                    period_cnt_next = '0;
                end
            end
            default: state_next = ST_INIT_WR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_INIT_WR;
            byte_cnt_reg   <= '0;
            tail_reg       <= 1'b0;
            tail_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            period_cnt_reg <= '0;
            cs_reg         <= 1'b1;
            y_reg          <= '0;
            z_reg          <= '0;
            valid_reg      <= 1'b0;
            init_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_cnt_reg   <= byte_cnt_next;
            tail_reg       <= tail_next;
            tail_cnt_reg   <= tail_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            period_cnt_reg <= period_cnt_next;
            cs_reg         <= cs_next;
            y_reg          <= y_next;
            z_reg          <= z_next;
            valid_reg      <= valid_next;
            init_done_reg  <= init_done_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cap
            always_ff @(posedge clk) begin
                if (!reset) cap_reg[gi] <= '0;
                else        cap_reg[gi] <= cap_next[gi];
            end
        end
    endgenerate

    assign CS        = cs_reg;
    assign busy      = ~cs_reg;
    assign Y_value   = y_reg;
    assign Z_value   = z_reg;
    assign valid     = valid_reg;
    assign init_done = init_done_reg;

endmodule
